// File: rtl/timebase_gen_if.sv
//-----------------------------------------------------------------------------
// Module     : timebase_gen_if
// Description: Control/status bundle of the timebase generator.
//              master : the generator (takes controls, drives strobes/irq)
//              slave  : the consumer (drives controls, takes strobes/irq)
//   resync     restart all counters (synchronous)
//   freeze     hold counters, suppress strobes
//   irq_ack    clear latched interrupt (level mode)
//   ce_o       NUM_CH one-clock enable strobes
//   sq_o       NUM_CH ~50% square-wave companions
//   irq_o      interrupt request
//   irq_miss_o saturating count of lost interrupt events
// Revision   : 1.0 - initial release
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface timebase_gen_if #(
  parameter int NUM_CH = 4
);
  logic              resync;
  logic              freeze;
  logic              irq_ack;
  logic [NUM_CH-1:0] ce_o;
  logic [NUM_CH-1:0] sq_o;
  logic              irq_o;
  logic [3:0]        irq_miss_o;

  modport master (
    input  resync, freeze, irq_ack,
    output ce_o, sq_o, irq_o, irq_miss_o
  );

  modport slave (
    output resync, freeze, irq_ack,
    input  ce_o, sq_o, irq_o, irq_miss_o
  );
endinterface

`default_nettype wire

// File: rtl/timebase_gen.sv
//-----------------------------------------------------------------------------
// Module     : timebase_gen
// Description: Multi-channel clock-enable generator with periodic interrupt
//              timer. Each channel produces a registered one-clock strobe
//              (ce_o) and a square-wave companion (sq_o). Channel IRQ_CH
//              clocks a modulo-IRQ_PERIOD interrupt counter that raises irq_o.
//              Build option TIMEBASE_FRAC_EN: channels become phase
//              accumulators (strobe = carry-out, square = accumulator MSB);
//              otherwise they are integer dividers by DIV_LIST entries.
// Ports      : clk    system clock
//              rst_l  asynchronous active-low reset
//              bus    timebase_gen_if.master (resync, freeze, irq_ack in;
//                     ce_o, sq_o, irq_o, irq_miss_o out)
// Revision   : 1.0 - initial release
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module timebase_gen #(
  parameter int                      NUM_CH     = 4,
  parameter int                      CNT_W      = 16,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_LIST   = {4{16'd16}},
  parameter logic [NUM_CH*CNT_W-1:0] INC_LIST   = {4{16'h1000}},
  parameter int                      IRQ_CH     = 0,
  parameter int                      IRQ_PERIOD = 14,
  parameter int                      IRQ_PHASE  = 12,
  parameter int                      IRQ_LEVEL  = 0
) (
  input  wire logic      clk,
  input  wire logic      rst_l,
  timebase_gen_if.master bus
);

  localparam logic [3:0] C_PHASE = 4'(IRQ_PHASE);
  localparam logic [3:0] C_LAST  = 4'(IRQ_PERIOD - 1);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("timebase_gen: NUM_CH must be 1..8");
  end
  if (IRQ_CH < 0 || IRQ_CH >= NUM_CH) begin : g_bad_irq_ch
    $error("timebase_gen: IRQ_CH out of range");
  end
  if (IRQ_PERIOD < 2 || IRQ_PERIOD > 16) begin : g_bad_period
    $error("timebase_gen: IRQ_PERIOD must be 2..16");
  end
  if (IRQ_PHASE < 0 || IRQ_PHASE >= IRQ_PERIOD) begin : g_bad_phase
    $error("timebase_gen: IRQ_PHASE must be below IRQ_PERIOD");
  end

  // Counters advance only when neither restart nor debug halt is active.
  logic              w_run;
  logic [NUM_CH-1:0] w_tick;   // channel strobe about to be registered this clk
  logic [NUM_CH-1:0] w_ce;
  logic [NUM_CH-1:0] w_sq;

  assign w_run = !bus.resync && !bus.freeze;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic r_ce;
    logic r_sq;

`ifdef TIMEBASE_FRAC_EN
    localparam logic [CNT_W-1:0] C_INC = INC_LIST[gi*CNT_W +: CNT_W];

    logic [CNT_W-1:0] r_acc;
    logic [CNT_W:0]   w_sum;

    assign w_sum       = {1'b0, r_acc} + {1'b0, C_INC};
    assign w_tick[gi]  = w_sum[CNT_W];

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        r_acc <= '0;
        r_ce  <= 1'b0;
        r_sq  <= 1'b0;
      end else if (bus.resync) begin
        r_acc <= '0;
        r_ce  <= 1'b0;
        r_sq  <= 1'b0;
      end else if (bus.freeze) begin
        r_ce  <= 1'b0;
      end else begin
        r_acc <= w_sum[CNT_W-1:0];
        r_ce  <= w_sum[CNT_W];
        r_sq  <= w_sum[CNT_W-1];
      end
    end
`else
    localparam logic [CNT_W-1:0] C_DIV = DIV_LIST[gi*CNT_W +: CNT_W];

    if (C_DIV == '0) begin : g_div_zero
      $error("timebase_gen: divider of 0 is not allowed");
    end

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap     = (r_cnt == C_DIV - 1'b1);
    assign w_tick[gi] = w_wrap;

    // sq_o is decoded from the pre-edge count so it shares ce_o's latency;
    // a divide-by-1 channel has no low half and keeps sq_o at 0.
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        r_cnt <= '0;
        r_ce  <= 1'b0;
        r_sq  <= 1'b0;
      end else if (bus.resync) begin
        r_cnt <= '0;
        r_ce  <= 1'b0;
        r_sq  <= 1'b0;
      end else if (bus.freeze) begin
        r_ce  <= 1'b0;
      end else begin
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        r_ce  <= w_wrap;
        r_sq  <= (C_DIV > 1) && (r_cnt >= (C_DIV >> 1));
      end
    end
`endif

    assign w_ce[gi] = r_ce;
    assign w_sq[gi] = r_sq;
  end

  // Interrupt counter steps on the same edge that registers ce_o[IRQ_CH].
  // The event is the tick taken while the counter sits at IRQ_PHASE, so
  // irq_o rises together with the (IRQ_PHASE+1)-th strobe.
  logic       w_irq_tick;
  logic       w_event;
  logic [3:0] r_irq_cnt;
  logic       r_irq;
  logic [3:0] r_miss;

  assign w_irq_tick = w_run && w_tick[IRQ_CH];
  assign w_event    = w_irq_tick && (r_irq_cnt == C_PHASE);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_irq_cnt <= '0;
      r_irq     <= 1'b0;
      r_miss    <= '0;
    end else if (bus.resync) begin
      r_irq_cnt <= '0;
      r_irq     <= 1'b0;
    end else if (bus.freeze) begin
      if (IRQ_LEVEL == 0) begin
        r_irq <= 1'b0;
      end
    end else begin
      if (w_irq_tick) begin
        r_irq_cnt <= (r_irq_cnt == C_LAST) ? 4'd0 : r_irq_cnt + 4'd1;
      end
      if (IRQ_LEVEL != 0) begin
        // An event outranks a simultaneous acknowledge.
        if (w_event) begin
          r_irq <= 1'b1;
          if (r_irq && (r_miss != 4'hF)) begin
            r_miss <= r_miss + 4'd1;
          end
        end else if (bus.irq_ack) begin
          r_irq <= 1'b0;
        end
      end else begin
        // Pulse lasts exactly one timebase period.
        if (w_event) begin
          r_irq <= 1'b1;
        end else if (w_irq_tick) begin
          r_irq <= 1'b0;
        end
      end
    end
  end

  assign bus.ce_o       = w_ce;
  assign bus.sq_o       = w_sq;
  assign bus.irq_o      = r_irq;
  assign bus.irq_miss_o = r_miss;

endmodule

`default_nettype wire
